// File: rtl/mem_seq_pkg.sv
// Shared types and helpers for the Avalon memory sequencer.
package mem_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    // Raw cpu_size encoding that has no size_t member; always rejected.
    localparam logic [1:0] SZ_ILLEGAL = 2'd3;

    // Active byte lanes for an access of the given size at the given offset.
    function automatic logic [3:0] gen_byteenable(input size_t size, input logic [1:0] addr);
        logic [3:0] be;
        case (size)
            SZ_WORD: be = 4'b1111;
            SZ_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b0001 << addr;
        endcase
        return be;
    endfunction

    // Raw size is taken so the illegal encoding can be rejected here too.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr);
        logic ok;
        case (size)
            2'd0:    ok = 1'b1;
            2'd1:    ok = ~addr[0];
            2'd2:    ok = (addr == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Replicate right-justified store data across every lane it could land in.
    function automatic logic [31:0] gen_writedata(input size_t size, input logic [31:0] wdata);
        logic [31:0] wd;
        case (size)
            SZ_BYTE: wd = {4{wdata[7:0]}};
            SZ_HALF: wd = {2{wdata[15:0]}};
            default: wd = wdata;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Lane extraction and sign/zero extension of Avalon read data.
module mem_load_align
    import mem_seq_pkg::*;
(
    input  logic [31:0] readdata_i,
    input  size_t       size_i,
    input  logic [1:0]  addr_i,
    input  logic        signed_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Pick the addressed lane, then extend it to a full word.
    always_comb begin
        byte_v = readdata_i[7:0];
        case (addr_i)
            2'd1:    byte_v = readdata_i[15:8];
            2'd2:    byte_v = readdata_i[23:16];
            2'd3:    byte_v = readdata_i[31:24];
            default: byte_v = readdata_i[7:0];
        endcase
        half_v = addr_i[1] ? readdata_i[31:16] : readdata_i[15:0];
        case (size_i)
            SZ_BYTE: data_o = {{24{signed_i & byte_v[7]}}, byte_v};
            SZ_HALF: data_o = {{16{signed_i & half_v[15]}}, half_v};
            default: data_o = readdata_i;
        endcase
    end

endmodule

// File: rtl/avalon_mem_sequencer.sv
// Sequences CPU fetch/load/store requests onto an Avalon-MM master port.
module avalon_mem_sequencer
    import mem_seq_pkg::*;
#(
    parameter int unsigned WAIT_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_signed,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_done,
    output logic        stall,
    output logic        misalign_err,
    output logic        timeout_err,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic        sgn_q;
    size_t       size_q;
    logic [1:0]  off_q;
    logic [31:0] address_q, writedata_q, rdata_q;
    logic [3:0]  be_q;
    logic        read_q, read_d, write_q, write_d;
    logic        misalign_q, misalign_d;
    logic        timeout_q, timeout_d;
    logic [31:0] cnt_q, cnt_d;
    logic        legal, accept;
    logic [31:0] load_data;

    assign legal  = is_aligned(cpu_size, cpu_addr[1:0]);
    assign accept = (state_q == IDLE) && cpu_req && legal;
    assign we_d   = accept ? cpu_we : we_q;

    mem_load_align u_load_align (
        .readdata_i (readdata),
        .size_i     (size_q),
        .addr_i     (off_q),
        .signed_i   (sgn_q),
        .data_o     (load_data)
    );

    // Next state, error flags and wait counter.
    always_comb begin
        state_d    = state_q;
        misalign_d = 1'b0;
        timeout_d  = timeout_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    if (legal) begin
                        state_d = BUS;
                        cnt_d   = '0;
                    end else begin
                        misalign_d = 1'b1;
                    end
                end
            end
            BUS: begin
                if (!waitrequest) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                    // Abandon the transfer once the slave has stalled too long.
                    if ((WAIT_TIMEOUT != 0) && (cnt_d == 32'(WAIT_TIMEOUT))) begin
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Strobes follow the next state so they come straight off flops.
        read_d  = (state_d == BUS) && !we_d;
        write_d = (state_d == BUS) &&  we_d;
    end

    // Control state, bus strobes and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            read_q     <= read_d;
            write_q    <= write_d;
            misalign_q <= misalign_d;
            timeout_q  <= timeout_d;
            cnt_q      <= cnt_d;
        end
    end

    // Request latch; held unchanged for the whole bus cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q        <= 1'b0;
            sgn_q       <= 1'b0;
            size_q      <= SZ_BYTE;
            off_q       <= 2'b00;
            address_q   <= '0;
            writedata_q <= '0;
            be_q        <= 4'b0000;
        end else if (accept) begin
            we_q        <= cpu_we;
            sgn_q       <= cpu_signed;
            size_q      <= size_t'(cpu_size);
            off_q       <= cpu_addr[1:0];
            address_q   <= {cpu_addr[31:2], 2'b00};
            writedata_q <= gen_writedata(size_t'(cpu_size), cpu_wdata);
            be_q        <= gen_byteenable(size_t'(cpu_size), cpu_addr[1:0]);
        end
    end

    // Formatted load data captured on the completing edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if ((state_q == BUS) && !waitrequest && !we_q) begin
            rdata_q <= load_data;
        end
    end

    assign address      = address_q;
    assign writedata    = writedata_q;
    assign byteenable   = be_q;
    assign read         = read_q;
    assign write        = write_q;
    assign cpu_rdata    = rdata_q;
    assign cpu_done     = (state_q == RESP);
    assign stall        = (state_q == BUS) || accept;
    assign misalign_err = misalign_q;
    assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_avalon_mem_sequencer.sv
// Self-checking bench for avalon_mem_sequencer: vector table plus corner sequences.
module tb_avalon_mem_sequencer;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_signed, waitrequest;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr, cpu_wdata, readdata;
    logic [31:0] cpu_rdata, address, writedata;
    logic        cpu_done, stall, misalign_err, timeout_err, read, write;
    logic [3:0]  byteenable;

    always #5 clk = ~clk;

    avalon_mem_sequencer #(.WAIT_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_signed(cpu_signed),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_done(cpu_done), .stall(stall), .misalign_err(misalign_err),
        .timeout_err(timeout_err), .address(address), .read(read), .write(write),
        .waitrequest(waitrequest), .writedata(writedata), .byteenable(byteenable),
        .readdata(readdata)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          nwait;
        logic        legal;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        we;
        logic [31:0] rdata;
    } sb_t;

    vec_t vecs[13];
    sb_t  sb_q[$];
    sb_t  sb_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int nwait, input logic legal,
                                input logic [3:0] be, input logic [31:0] wd,
                                input logic [31:0] exp_rdata);
        vec_t v;
        v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.nwait = nwait; v.legal = legal; v.be = be; v.wd = wd;
        v.exp_rdata = exp_rdata;
        return v;
    endfunction

    // Scoreboard: every completion must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!reset && cpu_done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 expected=0 at %0t", $time);
            end else begin
                sb_e = sb_q.pop_front();
                if (!sb_e.we) chk("sb_rdata", cpu_rdata, sb_e.rdata);
            end
        end
    end

    // Entered and left just after a rising edge with the DUT in IDLE.
    task automatic run_vec(input vec_t v, input int idx);
        int waited;
        string tag;
        tag = $sformatf("v%0d", idx);
        cpu_req = 1'b1; cpu_we = v.we; cpu_size = v.size; cpu_signed = v.sgn;
        cpu_addr = v.addr; cpu_wdata = v.wdata; readdata = v.rdata;
        waitrequest = (v.nwait != 0);
        if (v.legal) sb_q.push_back('{we: v.we, rdata: v.exp_rdata});
        @(negedge clk);
        chk({tag, "_stall0"}, stall, v.legal);
        chk({tag, "_rw0"}, {read, write}, 2'b00);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        if (!v.legal) begin
            @(negedge clk);
            chk({tag, "_misalign"}, misalign_err, 1'b1);
            chk({tag, "_rw_idle"}, {read, write}, 2'b00);
            chk({tag, "_done_none"}, cpu_done, 1'b0);
            @(posedge clk); #1;
            @(negedge clk);
            chk({tag, "_misalign_pulse"}, misalign_err, 1'b0);
            @(posedge clk); #1;
            return;
        end
        waited = 0;
        for (int c = 0; c <= v.nwait; c++) begin
            @(negedge clk);
            chk({tag, "_read"}, read, !v.we);
            chk({tag, "_write"}, write, v.we);
            chk({tag, "_addr"}, address, {v.addr[31:2], 2'b00});
            chk({tag, "_be"}, byteenable, v.be);
            if (v.we) chk({tag, "_wdata"}, writedata, v.wd);
            chk({tag, "_stall_bus"}, stall, 1'b1);
            chk({tag, "_done_early"}, cpu_done, 1'b0);
            @(posedge clk); #1;
            waited++;
            waitrequest = (waited < v.nwait);
        end
        @(negedge clk);
        chk({tag, "_done"}, cpu_done, 1'b1);
        chk({tag, "_stall_resp"}, stall, 1'b0);
        chk({tag, "_rw_resp"}, {read, write}, 2'b00);
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, "_done_pulse"}, cpu_done, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(0, 2, 0, 32'h100, 0, 32'hDEADBEEF, 0, 1, 4'b1111, 0, 32'hDEADBEEF);
        vecs[1]  = mk(0, 0, 1, 32'h103, 0, 32'h80FFFFFF, 0, 1, 4'b1000, 0, 32'hFFFFFF80);
        vecs[2]  = mk(0, 0, 0, 32'h103, 0, 32'h80FFFFFF, 0, 1, 4'b1000, 0, 32'h00000080);
        vecs[3]  = mk(1, 1, 0, 32'h202, 32'h1234ABCD, 0, 3, 1, 4'b1100, 32'hABCDABCD, 0);
        vecs[4]  = mk(1, 0, 0, 32'h101, 32'h000000A5, 0, 1, 1, 4'b0010, 32'hA5A5A5A5, 0);
        vecs[5]  = mk(0, 1, 1, 32'h200, 0, 32'h12348001, 0, 1, 4'b0011, 0, 32'hFFFF8001);
        vecs[6]  = mk(0, 1, 0, 32'h302, 0, 32'h9ABC0000, 2, 1, 4'b1100, 0, 32'h00009ABC);
        vecs[7]  = mk(1, 2, 0, 32'h040, 32'hCAFEF00D, 0, 2, 1, 4'b1111, 32'hCAFEF00D, 0);
        vecs[8]  = mk(0, 0, 1, 32'h005, 0, 32'h00007F00, 0, 1, 4'b0010, 0, 32'h0000007F);
        vecs[9]  = mk(0, 2, 0, 32'h101, 0, 32'h11111111, 0, 0, 4'b0000, 0, 0);
        vecs[10] = mk(0, 1, 0, 32'h203, 0, 32'h22222222, 0, 0, 4'b0000, 0, 0);
        vecs[11] = mk(0, 3, 0, 32'h000, 0, 32'h33333333, 0, 0, 4'b0000, 0, 0);
        vecs[12] = mk(0, 2, 1, 32'h008, 0, 32'h80000000, 1, 1, 4'b1111, 0, 32'h80000000);

        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 2'd0; cpu_signed = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; readdata = '0; waitrequest = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rw", {read, write}, 2'b00);
        chk("rst_flags", {cpu_done, misalign_err, timeout_err, stall}, 4'b0000);
        chk("rst_addr", address, 32'h0);
        chk("rst_wdata", writedata, 32'h0);
        chk("rst_rdata", cpu_rdata, 32'h0);
        chk("rst_be", byteenable, 4'b0000);
        @(posedge clk); #1;
        reset = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Slave stuck in waitrequest: transfer abandoned after TO wait cycles.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'd2; cpu_signed = 1'b0;
        cpu_addr = 32'h10; waitrequest = 1'b1;
        @(negedge clk);
        chk("to_stall0", stall, 1'b1);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        for (int c = 0; c < TO; c++) begin
            @(negedge clk);
            chk("to_read_hi", read, 1'b1);
            chk("to_err_lo", timeout_err, 1'b0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("to_read_drop", read, 1'b0);
        chk("to_err_set", timeout_err, 1'b1);
        chk("to_idle_stall", stall, 1'b0);
        chk("to_no_done", cpu_done, 1'b0);
        @(posedge clk); #1;
        waitrequest = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("to_err_sticky", timeout_err, 1'b1);
        chk("to_still_idle", {read, write, stall, cpu_done}, 4'b0000);
        @(posedge clk); #1;

        // Reset lands mid-wait; the bus cycle must be dropped.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'd2; cpu_addr = 32'h20; waitrequest = 1'b1;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(negedge clk);
        chk("rb_read_hi", read, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        waitrequest = 1'b0;
        @(negedge clk);
        chk("rb_read_lo", read, 1'b0);
        chk("rb_stall_lo", stall, 1'b0);
        chk("rb_err_clr", timeout_err, 1'b0);
        @(posedge clk); #1;
        run_vec(mk(0, 2, 0, 32'h10, 0, 32'h0BADF00D, 0, 1, 4'b1111, 0, 32'h0BADF00D), 99);

        repeat (2) @(posedge clk);
        chk("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
